// File: rtl/traffic_pkg.sv
// Shared phase encoding, legal lamp patterns and the phase sequencing rule
// used by the traffic lamp monitor and its decoder.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_UNKNOWN = 3'd0,
        PH_NS_G    = 3'd1,
        PH_NS_Y    = 3'd2,
        PH_EW_G    = 3'd3,
        PH_EW_Y    = 3'd4,
        PH_ILLEGAL = 3'd7
    } phase_e;

    // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
    localparam logic [5:0] LAMP_NS_G = 6'b100001;
    localparam logic [5:0] LAMP_NS_Y = 6'b010001;
    localparam logic [5:0] LAMP_EW_G = 6'b001100;
    localparam logic [5:0] LAMP_EW_Y = 6'b001010;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_NS_G: n = PH_NS_Y;
            PH_NS_Y: n = PH_EW_G;
            PH_EW_G: n = PH_EW_Y;
            PH_EW_Y: n = PH_NS_G;
            default: n = PH_ILLEGAL;
        endcase
        return n;
    endfunction

    function automatic logic is_lamp_phase(input phase_e p);
        return (p == PH_NS_G) || (p == PH_NS_Y) || (p == PH_EW_G) || (p == PH_EW_Y);
    endfunction

    function automatic logic is_green(input phase_e p);
        return (p == PH_NS_G) || (p == PH_EW_G);
    endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// Combinational lamp-pattern decoder: maps the six lamp bits onto a phase,
// with anything outside the four legal patterns reported as ILLEGAL.
module traffic_lamp_decode
    import traffic_pkg::*;
(
    input  logic   i_ns_green,
    input  logic   i_ns_yellow,
    input  logic   i_ns_red,
    input  logic   i_ew_green,
    input  logic   i_ew_yellow,
    input  logic   i_ew_red,
    output phase_e o_phase
);

    logic [5:0] w_lamps;

    assign w_lamps = {i_ns_green, i_ns_yellow, i_ns_red, i_ew_green, i_ew_yellow, i_ew_red};

    always_comb begin
        case (w_lamps)
            LAMP_NS_G: o_phase = PH_NS_G;
            LAMP_NS_Y: o_phase = PH_NS_Y;
            LAMP_EW_G: o_phase = PH_EW_G;
            LAMP_EW_Y: o_phase = PH_EW_Y;
            default:   o_phase = PH_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Observe-only checker for the intersection controller's lamps: tracks the
// current phase, times it in ticks and raises sticky order/timing/conflict faults.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned GRN_MIN = 10,
    parameter int unsigned GRN_MAX = 31,
    parameter int unsigned YEL_MIN = 3,
    parameter int unsigned YEL_MAX = 4,
    parameter int unsigned DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          ns_green,
    input  logic          ns_yellow,
    input  logic          ns_red,
    input  logic          ew_green,
    input  logic          ew_yellow,
    input  logic          ew_red,
    input  logic          fault_clear,
    output logic [2:0]    phase,
    output logic          phase_valid,
    output logic [2:0]    last_phase,
    output logic [DW-1:0] last_dur,
    output logic [15:0]   cycle_count,
    output logic          fault_conflict,
    output logic          fault_sequence,
    output logic          fault_timing,
    output logic          fault_any
);

    localparam logic [DW-1:0] GRN_MIN_C = DW'(GRN_MIN);
    localparam logic [DW-1:0] GRN_MAX_C = DW'(GRN_MAX);
    localparam logic [DW-1:0] YEL_MIN_C = DW'(YEL_MIN);
    localparam logic [DW-1:0] YEL_MAX_C = DW'(YEL_MAX);

    phase_e        w_dec;
    logic          w_change;
    logic          w_timed;
    logic          w_to_legal;
    logic [DW-1:0] w_lim_min;
    logic [DW-1:0] w_lim_max;
    logic          w_stuck;
    logic          w_wrap;
    logic          w_set_conflict;
    logic          w_set_sequence;
    logic          w_set_timing;

    phase_e        r_phase,       w_phase_nxt;
    logic          r_synced,      w_synced_nxt;
    logic [DW-1:0] r_cnt,         w_cnt_nxt;
    logic          r_valid,       w_valid_nxt;
    phase_e        r_last_phase,  w_last_phase_nxt;
    logic [DW-1:0] r_last_dur,    w_last_dur_nxt;
    logic [15:0]   r_cycle,       w_cycle_nxt;
    logic          r_fc,          w_fc_nxt;
    logic          r_fs,          w_fs_nxt;
    logic          r_ft,          w_ft_nxt;
    logic          r_fault_any,   w_fault_any_nxt;

    traffic_lamp_decode u_decode (
        .i_ns_green  (ns_green),
        .i_ns_yellow (ns_yellow),
        .i_ns_red    (ns_red),
        .i_ew_green  (ew_green),
        .i_ew_yellow (ew_yellow),
        .i_ew_red    (ew_red),
        .o_phase     (w_dec)
    );

    // Event classification. Before sync, illegal patterns are not change events.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        w_change       = 1'b0;
        w_lim_min      = YEL_MIN_C;
        w_lim_max      = YEL_MAX_C;
        w_to_legal     = (w_dec != PH_ILLEGAL);
        w_timed        = r_synced && is_lamp_phase(r_phase);

        if (r_synced) begin
            w_change = (w_dec != r_phase);
        end else begin
            w_change = w_to_legal;
        end

        if (is_green(r_phase)) begin
            w_lim_min = GRN_MIN_C;
            w_lim_max = GRN_MAX_C;
        end

        w_set_conflict = r_synced && w_change && !w_to_legal;
        w_set_sequence = w_timed && w_change && w_to_legal && (w_dec != next_phase(r_phase));
        // Overrun is flagged once, on the tick that carries the count past the limit.
        w_stuck        = w_timed && !w_change && tick && (r_cnt == w_lim_max);
        w_set_timing   = (w_timed && w_change && w_to_legal && (r_cnt < w_lim_min)) || w_stuck;
        w_wrap         = w_timed && w_change && (r_phase == PH_EW_Y) && (w_dec == PH_NS_G);
    end

    always_comb begin
        w_phase_nxt      = r_phase;
        w_synced_nxt     = r_synced;
        w_cnt_nxt        = r_cnt;
        w_valid_nxt      = 1'b0;
        w_last_phase_nxt = r_last_phase;
        w_last_dur_nxt   = r_last_dur;
        w_cycle_nxt      = r_cycle;

        if (w_change) begin
            w_phase_nxt      = w_dec;
            w_synced_nxt     = 1'b1;
            w_valid_nxt      = 1'b1;
            w_last_phase_nxt = r_phase;
            w_last_dur_nxt   = r_cnt;
            // A coincident tick already belongs to the phase being entered.
            w_cnt_nxt        = tick ? DW'(1) : '0;
        end else if (tick && !(&r_cnt)) begin
            w_cnt_nxt = r_cnt + DW'(1);
        end

        if (w_wrap) begin
            w_cycle_nxt = r_cycle + 16'd1;
        end

        w_fc_nxt        = w_set_conflict | (r_fc & ~fault_clear);
        w_fs_nxt        = w_set_sequence | (r_fs & ~fault_clear);
        w_ft_nxt        = w_set_timing   | (r_ft & ~fault_clear);
        w_fault_any_nxt = w_fc_nxt | w_fs_nxt | w_ft_nxt;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= PH_UNKNOWN;
            r_synced     <= 1'b0;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_last_phase <= PH_UNKNOWN;
            r_last_dur   <= '0;
            r_cycle      <= '0;
            r_fc         <= 1'b0;
            r_fs         <= 1'b0;
            r_ft         <= 1'b0;
            r_fault_any  <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_synced     <= w_synced_nxt;
            r_cnt        <= w_cnt_nxt;
            r_valid      <= w_valid_nxt;
            r_last_phase <= w_last_phase_nxt;
            r_last_dur   <= w_last_dur_nxt;
            r_cycle      <= w_cycle_nxt;
            r_fc         <= w_fc_nxt;
            r_fs         <= w_fs_nxt;
            r_ft         <= w_ft_nxt;
            r_fault_any  <= w_fault_any_nxt;
        end
    end

    assign phase          = r_phase;
    assign phase_valid    = r_valid;
    assign last_phase     = r_last_phase;
    assign last_dur       = r_last_dur;
    assign cycle_count    = r_cycle;
    assign fault_conflict = r_fc;
    assign fault_sequence = r_fs;
    assign fault_timing   = r_ft;
    assign fault_any      = r_fault_any;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Self-checking bench for traffic_lamp_monitor: table vectors, directed
// scenarios and random lamp traffic scored against a rule-level model.
`timescale 1ns/1ps
module tb_traffic_lamp_monitor;

    localparam int GRN_MIN = 10;
    localparam int GRN_MAX = 31;
    localparam int YEL_MIN = 3;
    localparam int YEL_MAX = 4;
    localparam int DW      = 8;

    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_NSG = 6'b100001;
    localparam logic [5:0] P_NSY = 6'b010001;
    localparam logic [5:0] P_EWG = 6'b001100;
    localparam logic [5:0] P_EWY = 6'b001010;
    localparam logic [5:0] P_BAD = 6'b100101;

    logic          clk = 1'b0;
    logic          reset, tick, fault_clear;
    logic [5:0]    lamps;
    logic          ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
    logic [2:0]    phase, last_phase;
    logic          phase_valid;
    logic [DW-1:0] last_dur;
    logic [15:0]   cycle_count;
    logic          fault_conflict, fault_sequence, fault_timing, fault_any;

    assign {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = lamps;

    always #5 clk = ~clk;

    traffic_lamp_monitor #(
        .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .DW(DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .ns_green       (ns_green),
        .ns_yellow      (ns_yellow),
        .ns_red         (ns_red),
        .ew_green       (ew_green),
        .ew_yellow      (ew_yellow),
        .ew_red         (ew_red),
        .fault_clear    (fault_clear),
        .phase          (phase),
        .phase_valid    (phase_valid),
        .last_phase     (last_phase),
        .last_dur       (last_dur),
        .cycle_count    (cycle_count),
        .fault_conflict (fault_conflict),
        .fault_sequence (fault_sequence),
        .fault_timing   (fault_timing),
        .fault_any      (fault_any)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (rule level) ----------------
    logic [5:0] pat_tab  [0:4] = '{P_OFF, P_NSG, P_NSY, P_EWG, P_EWY};
    int         succ_tab [0:4] = '{0, 2, 3, 4, 1};

    bit m_synced, m_overrun, m_fc, m_fs, m_ft, exp_valid;
    int m_phase, m_dur, m_cycles, exp_last, exp_dur;

    function automatic int decode_m(input logic [5:0] lm);
        for (int p = 1; p <= 4; p++) if (lm == pat_tab[p]) return p;
        return 7;
    endfunction

    function automatic int lo_lim(input int p);
        return (p == 1 || p == 3) ? GRN_MIN : YEL_MIN;
    endfunction

    function automatic int hi_lim(input int p);
        return (p == 1 || p == 3) ? GRN_MAX : YEL_MAX;
    endfunction

    task automatic model_update(input bit rst, input bit tk, input logic [5:0] lm, input bit clr);
        int d;
        bit sc, ss, st;
        if (rst) begin
            m_synced = 0; m_overrun = 0; m_fc = 0; m_fs = 0; m_ft = 0; exp_valid = 0;
            m_phase = 0; m_dur = 0; m_cycles = 0; exp_last = 0; exp_dur = 0;
            return;
        end
        d = decode_m(lm);
        sc = 0; ss = 0; st = 0; exp_valid = 0;
        if ((!m_synced && d == 7) || (m_synced && d == m_phase)) begin
            if (tk) begin
                m_dur = (m_dur >= 255) ? 255 : m_dur + 1;
                if (m_phase >= 1 && m_phase <= 4 && m_dur > hi_lim(m_phase) && !m_overrun) begin
                    st = 1;
                    m_overrun = 1;
                end
            end
        end else begin
            exp_valid = 1;
            exp_last  = m_phase;
            exp_dur   = m_dur;
            if (m_synced && d == 7) begin
                sc = 1;
            end else if (m_synced && m_phase != 7) begin
                if (d != succ_tab[m_phase]) ss = 1;
                if (m_dur < lo_lim(m_phase) || (m_dur > hi_lim(m_phase) && !m_overrun)) st = 1;
                if (m_phase == 4 && d == 1) m_cycles = (m_cycles + 1) % 65536;
            end
            m_synced  = 1;
            m_phase   = d;
            m_dur     = tk ? 1 : 0;
            m_overrun = 0;
        end
        m_fc = sc ? 1'b1 : (clr ? 1'b0 : m_fc);
        m_fs = ss ? 1'b1 : (clr ? 1'b0 : m_fs);
        m_ft = st ? 1'b1 : (clr ? 1'b0 : m_ft);
    endtask

    // ---------------- stimulus helpers ----------------
    int cap_last, cap_dur;

    task automatic step(input bit rst, input bit tk, input logic [5:0] lm, input bit clr);
        reset = rst; tick = tk; lamps = lm; fault_clear = clr;
        @(posedge clk);
        #1;
        model_update(rst, tk, lm, clr);
        check("phase", phase, m_phase);
        check("phase_valid", phase_valid, exp_valid);
        if (exp_valid) begin
            check("last_phase", last_phase, exp_last);
            check("last_dur", last_dur, exp_dur);
        end
        check("cycle_count", cycle_count, m_cycles);
        check("fault_conflict", fault_conflict, m_fc);
        check("fault_sequence", fault_sequence, m_fs);
        check("fault_timing", fault_timing, m_ft);
        check("fault_any", fault_any, m_fc | m_fs | m_ft);
        if (phase_valid) begin
            cap_last = last_phase;
            cap_dur  = last_dur;
        end
    endtask

    // Controller-like phase: n ticks, one every three clocks, lamps change with the first tick.
    task automatic drive_phase(input logic [5:0] lm, input int n);
        cap_last = -1;
        cap_dur  = -1;
        for (int i = 0; i < n; i++) begin
            step(0, 1, lm, 0);
            step(0, 0, lm, 0);
            step(0, 0, lm, 0);
        end
    endtask

    task automatic do_reset();
        step(1, 0, P_OFF, 0);
        step(1, 0, P_OFF, 0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit         rst;
        bit         tk;
        logic [5:0] lm;
        bit         clr;
        int         ph;
        bit         vld;
        int         lph;
        int         ldur;
        logic [2:0] flt;   // {conflict, sequence, timing}
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1, 0, P_OFF, 0, 0, 0, 0, 0, 3'b000};
        vecs[1]  = '{0, 1, P_OFF, 0, 0, 0, 0, 0, 3'b000};
        vecs[2]  = '{0, 0, P_NSG, 0, 1, 1, 0, 1, 3'b000};
        vecs[3]  = '{0, 1, P_NSG, 0, 1, 0, 0, 0, 3'b000};
        vecs[4]  = '{0, 1, P_NSG, 0, 1, 0, 0, 0, 3'b000};
        vecs[5]  = '{0, 0, P_BAD, 0, 7, 1, 1, 2, 3'b100};
        vecs[6]  = '{0, 1, P_NSG, 0, 1, 1, 7, 0, 3'b100};
        vecs[7]  = '{0, 0, P_NSG, 1, 1, 0, 0, 0, 3'b000};
        vecs[8]  = '{0, 1, P_EWG, 0, 3, 1, 1, 1, 3'b011};
        vecs[9]  = '{0, 0, P_EWG, 1, 3, 0, 0, 0, 3'b000};
        vecs[10] = '{1, 0, P_EWG, 0, 0, 0, 0, 0, 3'b000};
        vecs[11] = '{0, 1, P_OFF, 0, 0, 0, 0, 0, 3'b000};

        reset = 1; tick = 0; lamps = P_OFF; fault_clear = 0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].tk, vecs[i].lm, vecs[i].clr);
            check($sformatf("vec%0d phase", i), phase, vecs[i].ph);
            check($sformatf("vec%0d valid", i), phase_valid, vecs[i].vld);
            if (vecs[i].vld) begin
                check($sformatf("vec%0d last_phase", i), last_phase, vecs[i].lph);
                check($sformatf("vec%0d last_dur", i), last_dur, vecs[i].ldur);
            end
            check($sformatf("vec%0d faults", i), {fault_conflict, fault_sequence, fault_timing}, vecs[i].flt);
        end

        // Nominal: two full cycles, then extension and return to normal green.
        do_reset();
        repeat (3) step(0, 1, P_OFF, 0);
        drive_phase(P_NSG, 10);
        for (int c = 0; c < 2; c++) begin
            drive_phase(P_NSY, 3);
            check("nominal NS_G dur", cap_dur, 10);
            drive_phase(P_EWG, 10);
            check("nominal NS_Y dur", cap_dur, 3);
            drive_phase(P_EWY, 4);
            check("nominal EW_G dur", cap_dur, 10);
            drive_phase(P_NSG, 10);
            check("nominal EW_Y dur", cap_dur, 4);
        end
        check("nominal cycle_count", cycle_count, 2);
        check("nominal fault_any", fault_any, 0);

        drive_phase(P_NSY, 3);
        drive_phase(P_EWG, 10);
        drive_phase(P_EWY, 4);
        drive_phase(P_NSG, 20);
        drive_phase(P_NSY, 3);
        check("extension NS_G dur", cap_dur, 20);
        check("extension fault_timing", fault_timing, 0);
        drive_phase(P_EWG, 10);
        drive_phase(P_EWY, 4);
        drive_phase(P_NSG, 10);
        drive_phase(P_NSY, 3);
        check("post-extension NS_G dur", cap_dur, 10);
        check("post-extension cycle_count", cycle_count, 4);

        // Conflict mid NS_G, then resync.
        drive_phase(P_EWG, 10);
        drive_phase(P_EWY, 4);
        drive_phase(P_NSG, 5);
        step(0, 0, P_BAD, 0);
        check("conflict flag", fault_conflict, 1);
        check("conflict phase", phase, 7);
        step(0, 0, P_NSG, 0);
        check("resync phase", phase, 1);
        check("resync no sequence fault", fault_sequence, 0);
        check("resync cycle_count", cycle_count, 5);

        // Out-of-order transition.
        do_reset();
        drive_phase(P_NSG, 10);
        drive_phase(P_EWG, 1);
        check("sequence fault", fault_sequence, 1);
        check("sequence no timing", fault_timing, 0);

        // Short yellow.
        do_reset();
        drive_phase(P_NSG, 10);
        drive_phase(P_NSY, 2);
        drive_phase(P_EWG, 1);
        check("short yellow dur", cap_dur, 2);
        check("short yellow timing", fault_timing, 1);
        check("short yellow no sequence", fault_sequence, 0);

        // Stuck green, clear, no re-flag at exit, set beats clear.
        do_reset();
        drive_phase(P_NSG, 31);
        check("stuck before limit", fault_timing, 0);
        step(0, 1, P_NSG, 0);
        check("stuck at 32", fault_timing, 1);
        step(0, 0, P_NSG, 1);
        check("stuck cleared", fault_timing, 0);
        drive_phase(P_NSY, 3);
        check("stuck exit dur", cap_dur, 32);
        check("stuck no re-flag at exit", fault_timing, 0);
        step(0, 0, P_OFF, 0);
        step(0, 0, P_NSY, 0);
        step(0, 0, P_OFF, 1);
        check("set beats clear", fault_conflict, 1);

        // Reset in the middle of EW green.
        do_reset();
        drive_phase(P_NSG, 10);
        drive_phase(P_NSY, 3);
        step(0, 1, P_EWG, 0);
        step(0, 1, P_EWG, 0);
        step(1, 0, P_EWG, 0);
        check("reset phase", phase, 0);
        check("reset valid", phase_valid, 0);
        check("reset last_phase", last_phase, 0);
        check("reset last_dur", last_dur, 0);
        check("reset cycle_count", cycle_count, 0);
        check("reset fault_any", fault_any, 0);
        repeat (4) step(0, 1, P_OFF, 0);
        check("post-reset dark lamps", {fault_any, phase}, 0);

        // Random lamp traffic against the model.
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int r, len;
            logic [5:0] lm;
            r = $urandom_range(99);
            if (r < 75 && m_phase >= 1 && m_phase <= 4) lm = pat_tab[succ_tab[m_phase]];
            else if (r < 88) lm = pat_tab[$urandom_range(4, 1)];
            else lm = 6'($urandom);
            len = $urandom_range(120, 1);
            for (int c = 0; c < len; c++)
                step($urandom_range(399) == 0, $urandom_range(2) == 0, lm, $urandom_range(59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
